// File: rtl/sram_ctrl.sv
// Sequencer for an external asynchronous SRAM: one read or write at a time, registered strobes,
// programmable read/write wait states and a recovery gap that doubles as DQ bus turnaround.
module sram_ctrl #(
  parameter int AW      = 20,
  parameter int DW      = 8,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2,
  parameter int TURN    = 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic          i_req_we,
  input  logic [AW-1:0] i_req_addr,
  input  logic [DW-1:0] i_req_wdata,
  output logic          o_rsp_valid,
  output logic [DW-1:0] o_rsp_rdata,
  output logic [AW-1:0] o_sram_addr,
  output logic [DW-1:0] o_sram_dq_out,
  output logic          o_sram_dq_oe,
  input  logic [DW-1:0] i_sram_dq_in,
  output logic          o_sram_ce_n,
  output logic          o_sram_oe_n,
  output logic          o_sram_we_n
);

  // IDLE: ready | RD: OE# low | WR_SETUP/PULSE/HOLD: write phases | RECOVER: strobes high, turnaround
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD       = 3'd1;
  localparam logic [2:0] S_WR_SETUP = 3'd2;
  localparam logic [2:0] S_WR_PULSE = 3'd3;
  localparam logic [2:0] S_WR_HOLD  = 3'd4;
  localparam logic [2:0] S_RECOVER  = 3'd5;
  localparam int         CW         = 16;

  if (RD_WAIT < 1 || WR_WAIT < 1 || TURN < 1) begin : g_bad_param
    $error("sram_ctrl: RD_WAIT, WR_WAIT and TURN must all be >= 1");
  end

  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_ready;
  logic          r_rsp_valid;
  logic [DW-1:0] r_rdata;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_dq_out;
  logic          r_dq_oe;
  logic          r_ce_n;
  logic          r_oe_n;
  logic          r_we_n;
  logic          w_accept;

  assign w_accept = i_req_valid && r_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_addr      <= '0;
      r_dq_out    <= '0;
      r_dq_oe     <= 1'b0;
      r_ce_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_we_n      <= 1'b1;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_ready <= 1'b0;
            r_addr  <= i_req_addr;
            r_ce_n  <= 1'b0;
            if (i_req_we) begin
              r_state  <= S_WR_SETUP;
              r_dq_oe  <= 1'b1;
              r_dq_out <= i_req_wdata;
            end else begin
              r_state <= S_RD;
              r_oe_n  <= 1'b0;
              r_cnt   <= CW'(RD_WAIT - 1);
            end
          end else begin
            r_ready <= 1'b1;
          end
        end
        S_RD: begin
          if (r_cnt == '0) begin
            r_rdata     <= i_sram_dq_in;
            r_rsp_valid <= 1'b1;
            r_ce_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_cnt       <= CW'(TURN - 1);
            r_state     <= S_RECOVER;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_WR_SETUP: begin
          r_we_n  <= 1'b0;
          r_cnt   <= CW'(WR_WAIT - 1);
          r_state <= S_WR_PULSE;
        end
        S_WR_PULSE: begin
          if (r_cnt == '0) begin
            r_we_n  <= 1'b1;
            r_state <= S_WR_HOLD;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_WR_HOLD: begin
          r_ce_n      <= 1'b1;
          r_dq_oe     <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_cnt       <= CW'(TURN - 1);
          r_state     <= S_RECOVER;
        end
        S_RECOVER: begin
          if (r_cnt == '0) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
          r_dq_oe <= 1'b0;
          r_ce_n  <= 1'b1;
          r_oe_n  <= 1'b1;
          r_we_n  <= 1'b1;
        end
      endcase
    end
  end

  assign o_req_ready   = r_ready;
  assign o_rsp_valid   = r_rsp_valid;
  assign o_rsp_rdata   = r_rdata;
  assign o_sram_addr   = r_addr;
  assign o_sram_dq_out = r_dq_out;
  assign o_sram_dq_oe  = r_dq_oe;
  assign o_sram_ce_n   = r_ce_n;
  assign o_sram_oe_n   = r_oe_n;
  assign o_sram_we_n   = r_we_n;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: cycle-table model of the access timing plus a byte-array SRAM, checked every cycle.
module tb_sram_ctrl;

  localparam int A_RD = 2, A_WR = 2, A_TN = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // instance A: default timing, full model
  logic        a_valid = 1'b0, a_we = 1'b0;
  logic [19:0] a_req_addr = '0;
  logic [7:0]  a_wdata = '0;
  logic        a_ready, a_rsp, a_dq_oe, a_ce_n, a_oe_n, a_we_n;
  logic [7:0]  a_rdata, a_dq_out, a_dq_in;
  logic [19:0] a_addr;

  sram_ctrl #(.AW(20), .DW(8), .RD_WAIT(A_RD), .WR_WAIT(A_WR), .TURN(A_TN)) u_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(a_valid), .o_req_ready(a_ready), .i_req_we(a_we),
    .i_req_addr(a_req_addr), .i_req_wdata(a_wdata),
    .o_rsp_valid(a_rsp), .o_rsp_rdata(a_rdata),
    .o_sram_addr(a_addr), .o_sram_dq_out(a_dq_out), .o_sram_dq_oe(a_dq_oe),
    .i_sram_dq_in(a_dq_in), .o_sram_ce_n(a_ce_n), .o_sram_oe_n(a_oe_n), .o_sram_we_n(a_we_n)
  );

  // instance B: RD_WAIT=1, WR_WAIT=4, TURN=3
  logic        b_valid = 1'b0, b_we = 1'b0;
  logic [19:0] b_req_addr = '0;
  logic [7:0]  b_wdata = '0;
  logic        b_ready, b_rsp, b_dq_oe, b_ce_n, b_oe_n, b_we_n;
  logic [7:0]  b_rdata, b_dq_out, b_dq_in;
  logic [19:0] b_addr;

  sram_ctrl #(.AW(20), .DW(8), .RD_WAIT(1), .WR_WAIT(4), .TURN(3)) u_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(b_valid), .o_req_ready(b_ready), .i_req_we(b_we),
    .i_req_addr(b_req_addr), .i_req_wdata(b_wdata),
    .o_rsp_valid(b_rsp), .o_rsp_rdata(b_rdata),
    .o_sram_addr(b_addr), .o_sram_dq_out(b_dq_out), .o_sram_dq_oe(b_dq_oe),
    .i_sram_dq_in(b_dq_in), .o_sram_ce_n(b_ce_n), .o_sram_oe_n(b_oe_n), .o_sram_we_n(b_we_n)
  );
  assign b_dq_in = (!b_ce_n && !b_oe_n) ? 8'h77 : 8'h00;

  // pin-level SRAM seen by A, and the model's idea of memory contents
  logic [7:0] sram_mem [int];
  logic [7:0] exp_mem  [int];

  function automatic logic [7:0] srd(input logic [19:0] a);
    return sram_mem.exists(int'(a)) ? sram_mem[int'(a)] : 8'h00;
  endfunction
  function automatic logic [7:0] mrd(input logic [19:0] a);
    return exp_mem.exists(int'(a)) ? exp_mem[int'(a)] : 8'h00;
  endfunction

  assign a_dq_in = (!a_ce_n && !a_oe_n) ? srd(a_addr) : 8'h00;
  always @(posedge a_we_n) if (rst_n && !a_ce_n) sram_mem[int'(a_addr)] = a_dq_out;

  typedef struct packed { logic ce_n, oe_n, we_n, dq_oe, rsp; } strb_t;

  // expected strobes for cycle k of an access (k=1 is the cycle after the handshake)
  function automatic strb_t exp_strb(input logic we, input int k, input int r, input int w);
    strb_t s;
    s.ce_n = 1'b1; s.oe_n = 1'b1; s.we_n = 1'b1; s.dq_oe = 1'b0; s.rsp = 1'b0;
    if (!we) begin
      if (k >= 1 && k <= r) begin s.ce_n = 1'b0; s.oe_n = 1'b0; end
      else if (k == r + 1) s.rsp = 1'b1;
    end else begin
      if (k >= 1 && k <= w + 2) begin
        s.ce_n = 1'b0; s.dq_oe = 1'b1; s.we_n = !(k >= 2 && k <= w + 1);
      end else if (k == w + 3) s.rsp = 1'b1;
    end
    return s;
  endfunction

  logic        m_busy = 1'b0, m_rst_cyc = 1'b1, m_we = 1'b0, acc_flag = 1'b0, pend = 1'b0;
  int          m_k = 0, m_acc_cyc = 0, obs_rsp = -1, obs_rdy = -1;
  logic [19:0] m_addr = '0;
  logic [7:0]  m_wdata = '0, m_rdata = '0, obs_rdata = '0;
  logic        p_oe_n = 1'b1, p_dq_oe = 1'b0;

  always @(negedge clk) begin
    strb_t s;
    logic  e_rdy, bad;
    int    len;
    if (!rst_n) begin
      chk("rst_ce_n", a_ce_n, 1);  chk("rst_oe_n", a_oe_n, 1); chk("rst_we_n", a_we_n, 1);
      chk("rst_dq_oe", a_dq_oe, 0); chk("rst_ready", a_ready, 0); chk("rst_rsp", a_rsp, 0);
      chk("rst_addr", a_addr, 0);   chk("rst_rdata", a_rdata, 0); chk("rst_dq_out", a_dq_out, 0);
      m_busy = 1'b0; m_rst_cyc = 1'b1; m_rdata = '0; m_addr = '0; acc_flag = 1'b0; pend = 1'b0;
      p_oe_n = 1'b1; p_dq_oe = 1'b0;
    end else begin
      if (m_busy) begin s = exp_strb(m_we, m_k, A_RD, A_WR); e_rdy = 1'b0; end
      else begin s = exp_strb(1'b0, 0, A_RD, A_WR); e_rdy = !m_rst_cyc; end
      if (m_busy && s.rsp) begin
        if (m_we) exp_mem[int'(m_addr)] = m_wdata;
        else      m_rdata = mrd(m_addr);
      end
      chk("ce_n", a_ce_n, s.ce_n);   chk("oe_n", a_oe_n, s.oe_n); chk("we_n", a_we_n, s.we_n);
      chk("dq_oe", a_dq_oe, s.dq_oe); chk("rsp_valid", a_rsp, s.rsp);
      chk("req_ready", a_ready, e_rdy); chk("rsp_rdata", a_rdata, m_rdata);
      if (m_busy) chk("sram_addr", a_addr, m_addr);
      if (s.dq_oe) chk("dq_out", a_dq_out, m_wdata);
      bad = (!a_oe_n && a_dq_oe) || (!a_oe_n && !a_we_n) || (!a_we_n && (a_ce_n || !a_dq_oe)) ||
            (a_dq_oe && !p_oe_n) || (!a_oe_n && p_dq_oe);
      chk("invariants", bad, 0);
      p_oe_n = a_oe_n; p_dq_oe = a_dq_oe;
      if (pend) begin
        if (a_rsp) begin obs_rsp = cyc - m_acc_cyc; obs_rdata = a_rdata; end
        if (a_ready) begin obs_rdy = cyc - m_acc_cyc; pend = 1'b0; end
      end
      m_rst_cyc = 1'b0;
      acc_flag = 1'b0;
      if (m_busy) begin
        len = m_we ? (A_WR + 3 + A_TN) : (A_RD + 1 + A_TN);
        if (m_k + 1 == len) m_busy = 1'b0;
        else m_k++;
      end else if (e_rdy && a_valid) begin
        m_busy = 1'b1; m_k = 1; m_we = a_we; m_addr = a_req_addr;
        if (a_we) m_wdata = a_wdata;
        m_acc_cyc = cyc; acc_flag = 1'b1; pend = 1'b1; obs_rsp = -1; obs_rdy = -1;
      end
    end
  end

  // called and returns at posedge+1; hold keeps valid asserted after the handshake
  task automatic do_req(input logic we, input logic [19:0] addr, input logic [7:0] d, input logic hold);
    logic got = 1'b0;
    a_valid = 1'b1; a_we = we; a_req_addr = addr; a_wdata = d;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      if (acc_flag) begin got = 1'b1; break; end
    end
    chk("accept_timeout", got, 1);
    #1;
    if (!hold) a_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      if (!pend) break;
    end
    chk("done_timeout", pend, 0);
    #1;
  endtask

  task automatic b_access(input logic we, input logic [19:0] addr, input logic [7:0] d,
                          output int rc, output int yc, output logic [7:0] rd);
    logic rdy_seen = 1'b0;
    rc = -1; yc = -1; rd = '0;
    b_valid = 1'b1; b_we = we; b_req_addr = addr; b_wdata = d;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (b_ready) begin rdy_seen = 1'b1; break; end
    end
    chk("b_ready_timeout", rdy_seen, 1);
    @(posedge clk); #1;
    b_valid = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (b_rsp) begin rc = n; rd = b_rdata; end
      if (b_ready) begin yc = n; break; end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  logic [19:0] pool [8];
  int          rc, yc, acc0;
  logic [7:0]  rd;

  initial begin
    pool[0] = 20'h00000; pool[1] = 20'hFFFFF; pool[2] = 20'h00001; pool[3] = 20'h12345;
    pool[4] = 20'h80000; pool[5] = 20'h7FFFF; pool[6] = 20'hABCDE; pool[7] = 20'h00F00;
    sram_mem[int'(20'h12345)] = 8'hA5;
    exp_mem[int'(20'h12345)]  = 8'hA5;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset in the middle of WE# low
    do_req(1'b1, 20'h55555, 8'h11, 1'b0);
    @(posedge clk); #1;
    chk("t1_in_pulse_we_n", a_we_n, 0);
    rst_n = 1'b0;
    #1;
    chk("t1_we_n", a_we_n, 1); chk("t1_ce_n", a_ce_n, 1);
    chk("t1_dq_oe", a_dq_oe, 0); chk("t1_rsp", a_rsp, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); chk("t1_ready_before_edge", a_ready, 0);
    @(negedge clk); chk("t1_ready_after_edge", a_ready, 1);
    @(posedge clk); #1;

    // default read
    do_req(1'b0, 20'h12345, 8'h00, 1'b0);
    wait_done();
    chk("t2_rsp_cycle", obs_rsp, 3); chk("t2_ready_cycle", obs_rdy, 4); chk("t2_rdata", obs_rdata, 8'hA5);

    // default write at top address
    do_req(1'b1, 20'hFFFFF, 8'h3C, 1'b0);
    wait_done();
    chk("t3_rsp_cycle", obs_rsp, 5); chk("t3_ready_cycle", obs_rdy, 6);
    chk("t3_model_mem", mrd(20'hFFFFF), 8'h3C); chk("t3_sram_mem", srd(20'hFFFFF), 8'h3C);

    // valid held across a write then a read of the same location
    do_req(1'b1, 20'h00000, 8'h5A, 1'b1);
    acc0 = m_acc_cyc;
    do_req(1'b0, 20'h00000, 8'h00, 1'b0);
    chk("t4_second_accept_gap", m_acc_cyc - acc0, 6);
    wait_done();
    chk("t4_rdata", obs_rdata, 8'h5A);

    // RD_WAIT=1, WR_WAIT=4, TURN=3
    b_access(1'b0, 20'h00ABC, 8'h00, rc, yc, rd);
    chk("t5_rd_rsp_cycle", rc, 2); chk("t5_rd_ready_cycle", yc, 5); chk("t5_rd_data", rd, 8'h77);
    b_access(1'b1, 20'h00ABC, 8'hC3, rc, yc, rd);
    chk("t5_wr_rsp_cycle", rc, 7); chk("t5_wr_ready_cycle", yc, 10);
    chk("t5_wr_rdata_held", b_rdata, 8'h77);

    // random traffic against the model
    for (int i = 0; i < 1000; i++) begin
      logic hold;
      hold = (i != 999) && ($urandom_range(0, 3) != 0);
      do_req(1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], 8'($urandom_range(0, 255)), hold);
      if (!hold) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
    wait_done();
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
